// File: rtl/regfile_pkg.sv
// Shared register-file constants and the address-width helper.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_NREGS = 32;

  // Minimum number of address bits needed to index n entries.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mport_if.sv
// Write/read/snapshot bus of the multi-port register file.
interface regfile_mport_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = clog2(NREGS)
) ();

  logic                   we;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic [NREAD-1:0]       re;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*WIDTH-1:0] rdata;
  logic [NREAD-1:0]       rvalid;
  logic [NREGS*WIDTH-1:0] regs_flat;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata, rvalid, regs_flat
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata, rvalid, regs_flat
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: register select, zero/range masking and write bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned AW       = clog2(NREGS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREGS*WIDTH-1:0] mem,
  input  logic                   wr_ok,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   re,
  input  logic [AW-1:0]          raddr,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid
);

  logic [WIDTH-1:0] value;

  // Out-of-range addresses match no entry and fall through to zero;
  // wr_ok already excludes out-of-range and hardwired-zero targets.
  always_comb begin
    value = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (raddr == AW'(k)) value = mem[k*WIDTH +: WIDTH];
    end
    if (wr_ok && waddr == raddr) value = wdata;
    if (ZERO_REG && raddr == '0) value = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= value;
    end
  end

endmodule

// File: rtl/regfile_mport.sv
// Parametrised register file: one write port, NREAD registered read ports with bypass.
module regfile_mport
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned NREAD    = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic            clock,
  input logic            reset,
  regfile_mport_if.slave bus
);

  localparam int unsigned AW = clog2(NREGS);

  logic [NREGS*WIDTH-1:0] mem;
  logic                   wr_ok;
  logic [NREAD*WIDTH-1:0] rdata;
  logic [NREAD-1:0]       rvalid;

  always_comb begin
    wr_ok = bus.we && (32'(bus.waddr) < NREGS) && !(ZERO_REG && bus.waddr == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_ok) begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        if (bus.waddr == AW'(k)) mem[k*WIDTH +: WIDTH] <= bus.wdata;
      end
    end
  end

  always_comb begin
    bus.regs_flat = mem;
    if (ZERO_REG) bus.regs_flat[WIDTH-1:0] = '0;
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_port (
      .clock  (clock),
      .reset  (reset),
      .mem    (mem),
      .wr_ok  (wr_ok),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .re     (bus.re[g]),
      .raddr  (bus.raddr[g*AW +: AW]),
      .rdata  (rdata[g*WIDTH +: WIDTH]),
      .rvalid (rvalid[g])
    );
  end

  always_comb begin
    bus.rdata  = rdata;
    bus.rvalid = rvalid;
  end

endmodule

// File: tb/tb_regfile_mport.sv
// Directed + randomised bench over three register-file configurations.
module tb_regfile_mport;
  import regfile_pkg::*;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  regfile_mport_if #(.WIDTH(32), .NREGS(32), .NREAD(2)) b0 ();
  regfile_mport_if #(.WIDTH(32), .NREGS(32), .NREAD(2)) b1 ();
  regfile_mport_if #(.WIDTH(32), .NREGS(24), .NREAD(3)) b2 ();

  regfile_mport #(.WIDTH(32), .NREGS(32), .NREAD(2), .ZERO_REG(1'b1)) u0 (
    .clock(clock), .reset(reset), .bus(b0.slave));
  regfile_mport #(.WIDTH(32), .NREGS(32), .NREAD(2), .ZERO_REG(1'b0)) u1 (
    .clock(clock), .reset(reset), .bus(b1.slave));
  regfile_mport #(.WIDTH(32), .NREGS(24), .NREAD(3), .ZERO_REG(1'b1)) u2 (
    .clock(clock), .reset(reset), .bus(b2.slave));

  localparam int unsigned NR [3] = '{32, 32, 24};
  localparam bit          ZR [3] = '{1'b1, 1'b0, 1'b1};
  localparam int unsigned NP [3] = '{2, 2, 3};

  typedef struct {
    int unsigned dut;
    int unsigned port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl  [3][32];
  logic [31:0] last [3][3];
  bit          pw   [3];
  int unsigned pwa  [3];
  logic [31:0] pwd  [3];
  bit          pr   [3][3];
  int unsigned pra  [3][3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    tests++;
    assert (obs === expd) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expd);
    end
  endtask

  function automatic logic [31:0] get_rdata(input int unsigned d, input int unsigned p);
    case (d)
      0:       return 32'(b0.rdata >> (p*32));
      1:       return 32'(b1.rdata >> (p*32));
      default: return 32'(b2.rdata >> (p*32));
    endcase
  endfunction

  function automatic logic get_rvalid(input int unsigned d, input int unsigned p);
    case (d)
      0:       return 1'(b0.rvalid >> p);
      1:       return 1'(b1.rvalid >> p);
      default: return 1'(b2.rvalid >> p);
    endcase
  endfunction

  function automatic logic [31:0] get_flat(input int unsigned d, input int unsigned k);
    case (d)
      0:       return 32'(b0.regs_flat >> (k*32));
      1:       return 32'(b1.regs_flat >> (k*32));
      default: return 32'(b2.regs_flat >> (k*32));
    endcase
  endfunction

  // Reference value(a): zero/out-of-range masking, then same-edge write bypass, then storage.
  function automatic logic [31:0] model_val(input int unsigned d, input int unsigned a);
    if (a >= NR[d] || (ZR[d] && a == 0)) return '0;
    if (pw[d] && pwa[d] == a) return pwd[d];
    return mdl[d][a];
  endfunction

  task automatic clear_inputs();
    b0.we = 1'b0; b0.waddr = '0; b0.wdata = '0; b0.re = '0; b0.raddr = '0;
    b1.we = 1'b0; b1.waddr = '0; b1.wdata = '0; b1.re = '0; b1.raddr = '0;
    b2.we = 1'b0; b2.waddr = '0; b2.wdata = '0; b2.re = '0; b2.raddr = '0;
    for (int d = 0; d < 3; d++) begin
      pw[d] = 1'b0;
      for (int p = 0; p < 3; p++) pr[d][p] = 1'b0;
    end
  endtask

  task automatic wr(input int unsigned d, input int unsigned a, input logic [31:0] v);
    pw[d] = 1'b1; pwa[d] = a; pwd[d] = v;
    case (d)
      0:       begin b0.we = 1'b1; b0.waddr = 5'(a); b0.wdata = v; end
      1:       begin b1.we = 1'b1; b1.waddr = 5'(a); b1.wdata = v; end
      default: begin b2.we = 1'b1; b2.waddr = 5'(a); b2.wdata = v; end
    endcase
  endtask

  task automatic rd(input int unsigned d, input int unsigned p, input int unsigned a);
    pr[d][p] = 1'b1; pra[d][p] = a;
    case (d)
      0:       begin b0.re = b0.re | 2'(1 << p); b0.raddr = b0.raddr | 10'(a << (5*p)); end
      1:       begin b1.re = b1.re | 2'(1 << p); b1.raddr = b1.raddr | 10'(a << (5*p)); end
      default: begin b2.re = b2.re | 3'(1 << p); b2.raddr = b2.raddr | 15'(a << (5*p)); end
    endcase
  endtask

  task automatic check_outputs();
    for (int unsigned d = 0; d < 3; d++) begin
      for (int unsigned p = 0; p < NP[d]; p++) begin
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].dut == d && sb[i].port == p) idx = i;
        chk($sformatf("rvalid d%0d p%0d", d, p), 32'(get_rvalid(d, p)), 32'(idx >= 0));
        if (idx >= 0) begin
          if (get_rvalid(d, p))
            chk($sformatf("rdata d%0d p%0d", d, p), get_rdata(d, p), sb[idx].data);
          last[d][p] = sb[idx].data;
          sb.delete(idx);
        end else begin
          chk($sformatf("hold d%0d p%0d", d, p), get_rdata(d, p), last[d][p]);
        end
      end
      for (int unsigned k = 0; k < NR[d]; k++)
        chk($sformatf("flat d%0d r%0d", d, k), get_flat(d, k),
            (ZR[d] && k == 0) ? 32'h0 : mdl[d][k]);
    end
  endtask

  // Resolve expectations against the inputs set up for this edge, clock, then check.
  task automatic step();
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 32; k++) mdl[d][k] = '0;
        for (int p = 0; p < 3; p++) last[d][p] = '0;
      end
      sb.delete();
    end else begin
      for (int unsigned d = 0; d < 3; d++)
        for (int unsigned p = 0; p < NP[d]; p++)
          if (pr[d][p]) sb.push_back('{d, p, model_val(d, pra[d][p])});
      for (int unsigned d = 0; d < 3; d++)
        if (pw[d] && pwa[d] < NR[d] && !(ZR[d] && pwa[d] == 0)) mdl[d][pwa[d]] = pwd[d];
    end
    @(posedge clock);
    #1;
    clear_inputs();
    check_outputs();
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 32; k++) mdl[d][k] = '0;
      for (int p = 0; p < 3; p++) last[d][p] = '0;
    end
    clear_inputs();
    step();
    step();
    reset = 1'b0;

    // Reset clears storage and drops a coincident read.
    wr(0, 5, 32'hDEADBEEF);
    step();
    reset = 1'b1;
    rd(0, 0, 5);
    step();
    reset = 1'b0;
    rd(0, 0, 5);
    step();

    // Basic write then read, then hold with re low.
    wr(0, 7, 32'h12345678);
    step();
    rd(0, 0, 7);
    step();
    step();

    // Bypass on both ports.
    wr(0, 3, 32'h00000001);
    step();
    wr(0, 3, 32'hA5A5A5A5);
    rd(0, 0, 3);
    rd(0, 1, 3);
    step();

    // Register 0 hardwired vs ordinary.
    wr(0, 0, 32'hFFFFFFFF);
    wr(1, 0, 32'hFFFFFFFF);
    step();
    rd(0, 0, 0);
    rd(1, 0, 0);
    step();
    wr(0, 0, 32'h13572468);
    wr(1, 0, 32'h24681357);
    rd(0, 1, 0);
    rd(1, 1, 0);
    step();

    // Non-power-of-two depth, three independent ports.
    wr(2, 23, 32'hCAFE0023);
    step();
    wr(2, 5, 32'h00000505);
    step();
    wr(2, 30, 32'hBAD00030);
    step();
    rd(2, 0, 30);
    rd(2, 1, 23);
    rd(2, 2, 5);
    step();
    wr(2, 24, 32'h0BAD0024);
    rd(2, 0, 24);
    rd(2, 1, 5);
    rd(2, 2, 23);
    step();

    // Reset wins over a coincident write.
    wr(0, 9, 32'h00000055);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(0, 0, 9);
    step();

    // Back-to-back traffic on every port, with a reset in the middle.
    for (int n = 0; n < 60; n++) begin
      for (int unsigned d = 0; d < 3; d++) begin
        if ($urandom_range(0, 1) == 1)
          wr(d, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom);
        for (int unsigned p = 0; p < NP[d]; p++)
          if ($urandom_range(0, 3) != 0)
            rd(d, p, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      end
      reset = (n == 30);
      step();
    end
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
